// File: rtl/sa_params_pkg.sv
// Shared systolic-array parameters.
// Bus widths used across the operand path.
package sa_params_pkg;
    localparam int AXI_DATA_WIDTH = 32;
endpackage

// File: rtl/pp_tile_reader.sv
// Consume-side reader for the ping-pong tile buffer.
// Streams one tile out with latency hidden behind a 2-entry FIFO.
module pp_tile_reader
    import sa_params_pkg::*;
#(
    parameter int DATA_W = AXI_DATA_WIDTH,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   tile_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              consume_req,
    input  logic              consume_busy,
    input  logic              consume_done,
    input  logic              bank_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_bank
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        READ,
        FLUSH
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t state;
    state_t state_nxt;
    logic   req_nxt;
    logic   err_nxt;
    logic   done_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued;
    logic [ADDR_W:0]   returned;
    logic              inflight;

    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic       legal;
    logic       pop;
    logic [1:0] occ;
    logic       issue;
    logic       last_issue;

    assign legal = (tile_len != '0) &&
                   (!tile_len[ADDR_W] || (tile_len[ADDR_W-1:0] == '0));

    assign m_valid = (count != 2'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = fifo_last[rd_ptr];
    assign busy    = (state != IDLE);
    assign pop     = m_valid && m_ready;

    // Credit counts the slot freed by this cycle's pop, so a streaming
    // consumer never sees a bubble.
    assign occ        = count - {1'b0, pop} + {1'b0, inflight};
    assign issue      = (state == READ) && (occ < 2'd2);
    assign last_issue = ((issued + CNT_ONE) == len_q);

    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (legal) state_nxt = REQ;
                    else       err_nxt   = 1'b1;
                end
            end
            REQ: begin
                if (!consume_busy) begin
                    req_nxt   = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (consume_done) state_nxt = READ;
            end
            READ: begin
                if (issue && last_issue) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (pop && m_last) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            consume_req <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            consume_req <= req_nxt;
            err         <= err_nxt;
            done        <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q    <= '0;
            len_q     <= '0;
            issued    <= '0;
            returned  <= '0;
            inflight  <= 1'b0;
            rd_addr   <= '0;
            m_bank    <= 1'b0;
            fifo_last <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
        end else begin
            if (state == IDLE && start && legal) begin
                base_q <= base_addr;
                len_q  <= tile_len;
            end
            if (state == WAIT_ACK && consume_done) begin
                m_bank   <= bank_sel;
                rd_addr  <= base_q;
                issued   <= '0;
                returned <= '0;
            end
            if (issue) begin
                issued <= issued + CNT_ONE;
                if (!last_issue) rd_addr <= rd_addr + ADDR_ONE;
            end
            inflight <= issue;
            if (inflight) begin
                fifo_data[wr_ptr] <= rd_rdata;
                fifo_last[wr_ptr] <= (returned == (len_q - CNT_ONE));
                wr_ptr            <= ~wr_ptr;
                returned          <= returned + CNT_ONE;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_pp_tile_reader.sv
// Bench for pp_tile_reader: buffer stub, random data,
// expected stream rebuilt from base/len with modulo addressing.
module tb_pp_tile_reader;
    import sa_params_pkg::*;

    localparam int DW    = AXI_DATA_WIDTH;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   tile_len;
    logic          busy;
    logic          done;
    logic          err;
    logic          consume_req;
    logic          consume_busy;
    logic          consume_done;
    logic          bank_sel;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_bank;

    pp_tile_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .base_addr(base_addr), .tile_len(tile_len),
        .busy(busy), .done(done), .err(err),
        .consume_req(consume_req), .consume_busy(consume_busy),
        .consume_done(consume_done), .bank_sel(bank_sel),
        .rd_addr(rd_addr), .rd_rdata(rd_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_bank(m_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) rd_rdata <= mem[rd_addr];

    int vectors;
    int miscompares;

    logic [DW-1:0] q_data [$];
    bit            q_last [$];
    bit            q_bank [$];
    int            q_cyc  [$];
    int req_cnt, req_cyc, ack_cyc, done_cnt, done_cyc, err_cnt;
    int first_valid, stall_viol, busy_at_done, addr_first, addr_end;
    bit timed_out;

    task automatic run_tile(input int base, input int len, input bit rnd,
                            input int busy_cyc, input bit bank,
                            input int abort_after);
        int busy_left;
        bit ack_pend;
        bit stall_prev;
        logic [DW-1:0] pd;
        bit pl, pb, fin;
        int post, limit;
        q_data.delete(); q_last.delete(); q_bank.delete(); q_cyc.delete();
        req_cnt = 0; req_cyc = -1; ack_cyc = -1; done_cnt = 0;
        done_cyc = -1; err_cnt = 0; first_valid = -1; stall_viol = 0;
        busy_at_done = 0; addr_first = -1; addr_end = -1; timed_out = 0;
        ack_pend = 0; stall_prev = 0; fin = 0; post = 0;
        pd = '0; pl = 0; pb = 0;
        limit = 100 + busy_cyc + 4 * len;
        @(posedge clk); #1;
        start        = 1'b1;
        base_addr    = base[AW-1:0];
        tile_len     = len[AW:0];
        busy_left    = busy_cyc;
        consume_busy = (busy_left > 0);
        consume_done = 1'b0;
        bank_sel     = ~bank;
        m_ready      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int cyc = 0; cyc < limit; cyc++) begin
            @(negedge clk);
            if (consume_req) begin
                req_cnt++;
                if (req_cyc < 0) req_cyc = cyc;
                ack_pend = 1;
            end
            if (consume_done) ack_cyc = cyc;
            if (ack_cyc >= 0 && cyc == ack_cyc + 1) addr_first = int'(rd_addr);
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (stall_prev && !(m_valid && m_data === pd &&
                                m_last === pl && m_bank === pb))
                stall_viol++;
            stall_prev = m_valid && !m_ready;
            pd = m_data; pl = m_last; pb = m_bank;
            if (m_valid && m_ready) begin
                q_data.push_back(m_data);
                q_last.push_back(m_last);
                q_bank.push_back(m_bank);
                q_cyc.push_back(cyc);
            end
            if (err) err_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    addr_end = int'(rd_addr);
                end
                if (busy) busy_at_done++;
                fin = 1;
            end
            if (abort_after >= 0 && q_data.size() >= abort_after) break;
            if (fin) begin
                if (post == 3) break;
                post++;
            end
            @(posedge clk); #1;
            // A second start while busy must be ignored, even with a bad length.
            start    = (cyc == 2);
            tile_len = (cyc == 2) ? '0 : len[AW:0];
            if (busy_left > 0) busy_left--;
            consume_busy = (busy_left > 0);
            consume_done = ack_pend;
            bank_sel     = ack_pend ? bank : ~bank;
            ack_pend     = 0;
            m_ready      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        start = 1'b0;
        consume_done = 1'b0;
        consume_busy = 1'b0;
        m_ready = 1'b1;
        if (!fin && abort_after < 0) timed_out = 1;
    endtask

    task automatic test_tile(input string name, input int base, input int len,
                             input bit rnd, input int busy_cyc, input bit bank);
        logic [DW-1:0] exp_d;
        int exp_req;
        run_tile(base, len, rnd, busy_cyc, bank, -1);
        vectors++;
        if (timed_out) begin
            miscompares++;
            $display("FAIL %s timeout: done seen=%0d want 1", name, done_cnt);
        end
        vectors++;
        if (q_data.size() != len) begin
            miscompares++;
            $display("FAIL %s beats: got %0d want %0d", name, q_data.size(), len);
        end
        for (int i = 0; i < q_data.size() && i < len; i++) begin
            exp_d = mem[(base + i) % DEPTH];
            vectors++;
            if (q_data[i] !== exp_d || q_last[i] !== (i == len - 1) ||
                q_bank[i] !== bank) begin
                miscompares++;
                $display("FAIL %s beat %0d: got d=%h l=%0b b=%0b want d=%h l=%0b b=%0b",
                         name, i, q_data[i], q_last[i], q_bank[i],
                         exp_d, (i == len - 1), bank);
            end
        end
        vectors++;
        if (req_cnt != 1 || done_cnt != 1 || err_cnt != 0) begin
            miscompares++;
            $display("FAIL %s pulses: req=%0d done=%0d err=%0d want 1/1/0",
                     name, req_cnt, done_cnt, err_cnt);
        end
        vectors++;
        if (busy_at_done != 0 || stall_viol != 0) begin
            miscompares++;
            $display("FAIL %s busy_at_done=%0d stall_viol=%0d want 0/0",
                     name, busy_at_done, stall_viol);
        end
        exp_req = (busy_cyc + 1 > 2) ? busy_cyc + 1 : 2;
        vectors++;
        if (req_cyc != exp_req) begin
            miscompares++;
            $display("FAIL %s req_cycle: got %0d want %0d", name, req_cyc, exp_req);
        end
        vectors++;
        if (first_valid != ack_cyc + 3 || addr_first != base % DEPTH) begin
            miscompares++;
            $display("FAIL %s first read: valid@%0d addr=%0d want valid@%0d addr=%0d",
                     name, first_valid, addr_first, ack_cyc + 3, base % DEPTH);
        end
        if (q_cyc.size() == len) begin
            vectors++;
            if (done_cyc != q_cyc[len-1] + 1) begin
                miscompares++;
                $display("FAIL %s done_cycle: got %0d want %0d",
                         name, done_cyc, q_cyc[len-1] + 1);
            end
            if (!rnd) begin
                vectors++;
                if (q_cyc[len-1] - q_cyc[0] != len - 1) begin
                    miscompares++;
                    $display("FAIL %s throughput: span %0d want %0d",
                             name, q_cyc[len-1] - q_cyc[0], len - 1);
                end
            end
        end
        vectors++;
        if (addr_end != (base + len - 1) % DEPTH) begin
            miscompares++;
            $display("FAIL %s rd_addr_hold: got %0d want %0d",
                     name, addr_end, (base + len - 1) % DEPTH);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, err, consume_req, m_valid, m_last, m_bank,
             rd_addr, m_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: busy=%0b done=%0b err=%0b req=%0b v=%0b l=%0b b=%0b a=%0d d=%h want all 0",
                     busy, done, err, consume_req, m_valid, m_last, m_bank,
                     rd_addr, m_data);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_illegal(input int len);
        int ecnt, ecyc, bcnt, rcnt;
        ecnt = 0; ecyc = -1; bcnt = 0; rcnt = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        tile_len  = len[AW:0];
        base_addr = AW'($urandom_range(0, DEPTH - 1));
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (err) begin ecnt++; ecyc = cyc; end
            if (busy) bcnt++;
            if (consume_req) rcnt++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        vectors++;
        if (ecnt != 1 || ecyc != 1) begin
            miscompares++;
            $display("FAIL illegal_%0d err: count=%0d cycle=%0d want 1 at 1",
                     len, ecnt, ecyc);
        end
        vectors++;
        if (bcnt != 0 || rcnt != 0) begin
            miscompares++;
            $display("FAIL illegal_%0d activity: busy=%0d req=%0d want 0/0",
                     len, bcnt, rcnt);
        end
    endtask

    task automatic test_reset_mid();
        int base, extra;
        bit bank;
        base  = $urandom_range(0, DEPTH - 1);
        bank  = 1'($urandom_range(0, 1));
        extra = 0;
        run_tile(base, 10, 0, 0, bank, 3);
        vectors++;
        if (q_data.size() != 3) begin
            miscompares++;
            $display("FAIL reset_mid beats_before: got %0d want 3", q_data.size());
        end
        rstn = 1'b0;
        #1;
        vectors++;
        if ({busy, done, err, consume_req, m_valid, m_last, m_bank,
             rd_addr, m_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid outputs: busy=%0b v=%0b l=%0b b=%0b a=%0d d=%h want all 0",
                     busy, m_valid, m_last, m_bank, rd_addr, m_data);
        end
        repeat (3) begin
            @(negedge clk);
            if (consume_req || done || busy) extra++;
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (consume_req || done || busy || m_valid) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL reset_mid residue: got %0d active cycles want 0", extra);
        end
        test_tile("post_reset", $urandom_range(0, DEPTH - 1), 2, 0, 0, 1'b1);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rstn         = 1'b0;
        start        = 1'b0;
        base_addr    = '0;
        tile_len     = '0;
        consume_busy = 1'b0;
        consume_done = 1'b0;
        bank_sel     = 1'b0;
        m_ready      = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        test_reset();
        test_tile("basic", 0, 8, 0, 0, 1'b0);
        test_tile("wrap", 1022, 4, 0, 0, 1'b0);
        test_tile("backpressure", $urandom_range(0, DEPTH - 1), 16, 1, 0,
                  1'($urandom_range(0, 1)));
        test_illegal(0);
        test_illegal(1025);
        test_tile("len1", $urandom_range(0, DEPTH - 1), 1, 0, 0, 1'b0);
        test_tile("gating", $urandom_range(0, DEPTH - 1), 6, 1, 5, 1'b1);
        test_reset_mid();
        for (int t = 0; t < 4; t++)
            test_tile("random", $urandom_range(0, DEPTH - 1),
                      $urandom_range(1, 40), 1, $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        test_tile("full_bank", $urandom_range(0, DEPTH - 1), DEPTH, 1, 2,
                  1'($urandom_range(0, 1)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
